// File: rtl/adder_share_ctrl_if.sv
// rtl/adder_share_ctrl_if.sv - request/response bundle between requesters and the shared-adder controller
interface adder_share_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_carry;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  resp_valid, resp_id, resp_sum, resp_carry,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output resp_valid, resp_id, resp_sum, resp_carry,
    input  resp_ready
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin scheduler sharing one registered adder between two requesters
module adder_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  adder_share_ctrl_if.slave   bus,
  output logic                busy,
  output logic [3:0]          o_cnt_1,
  output logic [3:0]          o_cnt_2
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic             rr_ptr_q,     rr_ptr_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic             id_q,         id_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q,    resp_id_d;
  logic [WIDTH-1:0] sum_q,        sum_d;
  logic             carry_q,      carry_d;
  logic [3:0]       cnt0_q,       cnt0_d;
  logic [3:0]       cnt1_q,       cnt1_d;

  logic gnt0;
  logic gnt1;

  // Grant only in IDLE; rr_ptr breaks the tie when both requesters are valid.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == ST_IDLE) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
      gnt1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0) begin
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          id_d    = 1'b0;
          state_d = ST_EXEC;
        end else if (gnt1) begin
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          id_d    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
        resp_id_d        = id_q;
        resp_valid_d     = 1'b1;
        state_d          = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = ~resp_id_q;
          if (resp_id_q) cnt1_d = cnt1_q + 4'd1;
          else           cnt0_d = cnt0_q + 4'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cnt0_q       <= 4'd0;
      cnt1_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_carry = carry_q;
  assign busy           = (state_q != ST_IDLE);
  assign o_cnt_1        = cnt0_q;
  assign o_cnt_2        = cnt1_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - directed self-checking bench for adder_share_ctrl
module tb_adder_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] cnt1;
  logic [3:0] cnt2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  adder_share_ctrl_if #(.WIDTH(4)) bus ();

  adder_share_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .o_cnt_1 (cnt1),
    .o_cnt_2 (cnt2)
  );

  task automatic idle_inputs;
    bus.req0_valid = 1'b0; bus.req0_a = 4'h0; bus.req0_b = 4'h0;
    bus.req1_valid = 1'b0; bus.req1_a = 4'h0; bus.req1_b = 4'h0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present a pair, hold it until accepted, then withdraw; returns 1 pointing just after the accept edge.
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, output bit ok);
    ok = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((id && bus.req1_ready) || (!id && bus.req0_ready)) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.resp_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.req0_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0h exp=0", bus.resp_valid); end
    checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id got=%0h exp=0", bus.resp_id); end
    checks++; if (bus.resp_sum !== 4'h0) begin errors++; $display("FAIL reset_resp_sum got=%0h exp=0", bus.resp_sum); end
    checks++; if (bus.resp_carry !== 1'b0) begin errors++; $display("FAIL reset_resp_carry got=%0h exp=0", bus.resp_carry); end
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
    checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%0h exp=0", bus.req0_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd4;
    bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got=%0h exp=1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got=%0h exp=0", bus.req1_ready); end
    @(posedge clk); #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_pulse got=%0h exp=0", bus.req0_ready); end
    bus.req0_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec got=%0h exp=1", busy); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%0h exp=0", bus.resp_valid); end
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid got=%0h exp=1", bus.resp_valid); end
    checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL single_resp_id got=%0h exp=0", bus.resp_id); end
    checks++; if (bus.resp_sum !== 4'd7) begin errors++; $display("FAIL single_resp_sum got=%0h exp=7", bus.resp_sum); end
    checks++; if (bus.resp_carry !== 1'b0) begin errors++; $display("FAIL single_resp_carry got=%0h exp=0", bus.resp_carry); end
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%0h exp=0", bus.resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%0h exp=0", busy); end
    checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL single_cnt1 got=%0d exp=1", cnt1); end
    checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL single_cnt2 got=%0d exp=0", cnt2); end
  endtask

  task automatic test_contention;
    bit ok;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_resp(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL contention_timeout resp=%0d got=%0h exp=1", k, ok); end
      checks++; if (bus.resp_id !== k[0]) begin errors++; $display("FAIL contention_id resp=%0d got=%0h exp=%0h", k, bus.resp_id, k[0]); end
      checks++; if (bus.resp_sum !== (k[0] ? 4'd4 : 4'd2)) begin errors++; $display("FAIL contention_sum resp=%0d got=%0h exp=%0h", k, bus.resp_sum, (k[0] ? 4'd4 : 4'd2)); end
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++; if (cnt1 !== 4'd3) begin errors++; $display("FAIL contention_cnt1 got=%0d exp=3", cnt1); end
    checks++; if (cnt2 !== 4'd3) begin errors++; $display("FAIL contention_cnt2 got=%0d exp=3", cnt2); end
  endtask

  task automatic test_backpressure;
    bit ok;
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd6;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_req0_ready got=%0h exp=1", bus.req0_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd3;
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid got=%0h exp=1", bus.resp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 4'hB || bus.resp_id !== 1'b0 || bus.resp_carry !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got v=%0h id=%0h sum=%0h c=%0h exp v=1 id=0 sum=b c=0",
                 i, bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry);
      end
      checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_wait cycle=%0d got=%0h exp=0", i, bus.req1_ready); end
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_same_cycle got=%0h exp=0", bus.req1_ready); end
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%0h exp=0", bus.resp_valid); end
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_granted got=%0h exp=1", bus.req1_ready); end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_resp(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout got=%0h exp=1", ok); end
    checks++; if (bus.resp_id !== 1'b1 || bus.resp_sum !== 4'd5) begin errors++; $display("FAIL bp_second got id=%0h sum=%0h exp id=1 sum=5", bus.resp_id, bus.resp_sum); end
    @(posedge clk); #1;
    checks++; if (cnt1 !== 4'd4 || cnt2 !== 4'd4) begin errors++; $display("FAIL bp_counts got=%0d/%0d exp=4/4", cnt1, cnt2); end
  endtask

  task automatic test_overflow;
    bit ok;
    bus.resp_ready = 1'b1;
    issue(1'b1, 4'hF, 4'h1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_issue1 got=%0h exp=1", ok); end
    wait_resp(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_timeout1 got=%0h exp=1", ok); end
    checks++; if (bus.resp_sum !== 4'h0 || bus.resp_carry !== 1'b1 || bus.resp_id !== 1'b1) begin
      errors++; $display("FAIL ovf_f_plus_1 got sum=%0h c=%0h id=%0h exp sum=0 c=1 id=1", bus.resp_sum, bus.resp_carry, bus.resp_id);
    end
    @(posedge clk); #1;
    issue(1'b0, 4'hF, 4'hF, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_issue0 got=%0h exp=1", ok); end
    wait_resp(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_timeout0 got=%0h exp=1", ok); end
    checks++; if (bus.resp_sum !== 4'hE || bus.resp_carry !== 1'b1 || bus.resp_id !== 1'b0) begin
      errors++; $display("FAIL ovf_f_plus_f got sum=%0h c=%0h id=%0h exp sum=e c=1 id=0", bus.resp_sum, bus.resp_carry, bus.resp_id);
    end
    @(posedge clk); #1;
    checks++; if (cnt1 !== 4'd5 || cnt2 !== 4'd5) begin errors++; $display("FAIL ovf_counts got=%0d/%0d exp=5/5", cnt1, cnt2); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [3:0] av;
    logic [3:0] exp_cnt;
    apply_reset();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      av = 4'(k);
      exp_cnt = 4'(k + 1);
      issue(1'b0, av, 4'h1, ok);
      wait_resp(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_timeout op=%0d got=%0h exp=1", k, ok); end
      @(posedge clk); #1;
      checks++; if (cnt1 !== exp_cnt) begin errors++; $display("FAIL wrap_cnt1 op=%0d got=%0d exp=%0d", k, cnt1, exp_cnt); end
      checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL wrap_cnt2 op=%0d got=%0d exp=0", k, cnt2); end
    end
  endtask

  task automatic test_reset_in_resp;
    bit ok;
    bus.resp_ready = 1'b1;
    issue(1'b1, 4'd2, 4'd2, ok);
    wait_resp(ok);
    @(posedge clk); #1;
    issue(1'b0, 4'd1, 4'd1, ok);
    wait_resp(ok);
    @(posedge clk); #1;
    checks++; if (cnt1 !== 4'd1 || cnt2 !== 4'd1) begin errors++; $display("FAIL rst_pre_counts got=%0d/%0d exp=1/1", cnt1, cnt2); end
    bus.resp_ready = 1'b0;
    issue(1'b1, 4'd3, 4'd3, ok);
    wait_resp(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_reach_resp got=%0h exp=1", ok); end
    bus.req0_valid = 1'b1; bus.req0_a = 4'd4; bus.req0_b = 4'd5;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd6; bus.req1_b = 4'd7;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%0h exp=0", bus.resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (cnt1 !== 4'd0 || cnt2 !== 4'd0) begin errors++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", cnt1, cnt2); end
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_held got=%0h/%0h exp=0/0", bus.req0_ready, bus.req1_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_regrant got=%0h/%0h exp=1/0", bus.req0_ready, bus.req1_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_resp(ok);
    checks++; if (ok !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_sum !== 4'd9) begin
      errors++; $display("FAIL rst_after_resp got ok=%0h id=%0h sum=%0h exp ok=1 id=0 sum=9", ok, bus.resp_id, bus.resp_sum);
    end
    @(posedge clk); #1;
    checks++; if (cnt1 !== 4'd1 || cnt2 !== 4'd0) begin errors++; $display("FAIL rst_post_counts got=%0d/%0d exp=1/0", cnt1, cnt2); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Round-robin controller that shares one registered WIDTH-bit adder between two requesters. Each requester presents an operand pair through a valid/ready handshake. The controller grants one request at a time, sequences the operation through a small FSM, and returns sum, carry and requester ID over a response handshake. Two 4-bit service counters, in the style of the existing counter outputs, report completed operations per requester. The block sits in front of the shared adder datapath as its sole scheduler.

## Interface
- WIDTH, 4, operand and sum width in bits
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has an operand pair
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_ready  output  1  requester 0 pair accepted this cycle
- req1_valid  input  1  requester 1 has an operand pair
- req1_a, req1_b  input  WIDTH  requester 1 operands
- req1_ready  output  1  requester 1 pair accepted this cycle
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  1  requester that owns the result
- resp_sum  output  WIDTH  (a+b) mod 2^WIDTH
- resp_carry  output  1  bit WIDTH of a+b
- busy  output  1  FSM not in IDLE
- o_cnt_1  output  4  completed responses for requester 0
- o_cnt_2  output  4  completed responses for requester 1

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from req*_valid and rr_ptr.
  - One valid: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - reqN_ready = (state==IDLE) && granted N. At most one ready is high per cycle.
  - On handshake, the block latches a, b and id, then moves to EXEC.
  - If no request is valid, the FSM stays in IDLE.
- EXEC (exactly 1 cycle):
  - {resp_carry, resp_sum} <= latched a + latched b, computed as a WIDTH+1-bit add.
  - resp_id <= latched id; resp_valid <= 1; FSM moves to RESP.
- RESP:
  - resp_valid, resp_id, resp_sum and resp_carry hold stable until resp_valid && resp_ready.
  - On that handshake: resp_valid <= 0, rr_ptr <= ~resp_id, the counter for resp_id increments, and the FSM returns to IDLE.
- Counters: 4-bit, wrap 15 -> 0, increment only on a response handshake.
- Both reqN_ready are 0 in EXEC and RESP. Requesters must hold valid and operands until ready.
- Requester inputs are ignored outside IDLE.
- resp_ready is ignored outside RESP.

## Timing
- Reset values (effective at the first rising edge with rst=1):
  - state=IDLE, rr_ptr=0, busy=0.
  - resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0.
  - o_cnt_1=0, o_cnt_2=0.
  - reqN_ready=0 while rst=1.
- Request handshake at edge E means resp_valid=1 from edge E+2.
- If resp_ready is already high, the response handshake occurs at edge E+2 and IDLE resumes after E+2. The next request can be accepted at edge E+3.
- Peak throughput: one operation per 3 cycles.
- busy=1 from edge E+1 up to and including the response-handshake edge.
- Simultaneous valids with rr_ptr=0 grant requester 0. Continuous contention alternates 0,1,0,1.
- A request arriving in EXEC or RESP waits. It is granted in the next IDLE cycle per rr_ptr.
- Reset mid-operation (EXEC or RESP) aborts the operation. The result is discarded, no counter increments, and all outputs take their reset values at that edge.
- Overflow: a=4'hF, b=4'h1 gives sum=4'h0, carry=1. No saturation.

## Test plan
- Single request: after reset, req0 a=3, b=4 held valid, resp_ready=1.
  - req0_ready pulses for 1 cycle.
  - resp_valid rises 2 edges later with id=0, sum=7, carry=0.
  - o_cnt_1=1.
- Contention: both valid continuously (req0 1+1, req1 2+2), resp_ready=1.
  - Responses alternate id 0 (sum 2), 1 (sum 4), 0, 1, ...
  - After 6 responses, o_cnt_1=3 and o_cnt_2=3.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid, with req1 valid meanwhile.
  - resp fields stay stable.
  - req1_ready stays 0 until the cycle after resp_ready=1.
- Overflow/carry: req1 with a=F, b=1 gives sum=0, carry=1; req0 with a=F, b=F gives sum=E, carry=1.
- Counter wrap: 16 req0-only operations give o_cnt_1 sequence 1..15 then 0, while o_cnt_2 stays 0.
- Reset in RESP: assert rst for 1 cycle while resp_valid=1.
  - Next cycle: resp_valid=0, busy=0, counters unchanged from reset (0).
  - Pending request re-granted to requester 0.
